// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Initiator side of the ALU start/op_done handshake. Commands (operands,
//   opcode, tag) are buffered in a small FIFO and issued one at a time to the
//   ALU. alu_start is held for ALU_LAT cycles, then one settle cycle follows.
//   The result and flags are then captured and returned on a valid/ready
//   response port.
//
//   Optional feature: define ALU_SEQ_CHAIN_EN to store cmd_chain in the FIFO.
//   A chained command then takes operand A from the last captured result.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (cmd_ready = FIFO not full)
//   cmd_a, cmd_b, cmd_op       operands and opcode (opcode passed unchecked)
//   cmd_tag, cmd_chain         opaque tag, chaining request (feature only)
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_flags        captured y_out, {c_out,zflag,sflag,cflag,pflag}
//   rsp_tag                    tag of the completed command
//   alu_a_in..alu_start        drive to the ALU
//   alu_y_out, alu_*flag       results from the ALU
//   busy                       state not IDLE or FIFO not empty
module alu_cmd_sequencer #(
  parameter int unsigned N       = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned ALU_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N-1:0]     cmd_a,
  input  logic [N-1:0]     cmd_b,
  input  logic [3:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  input  logic             cmd_chain,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_data,
  output logic [4:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [N-1:0]     alu_a_in,
  output logic [N-1:0]     alu_b_in,
  output logic [3:0]       alu_opcode,
  output logic             alu_start,
  input  logic [N-1:0]     alu_y_out,
  input  logic             alu_c_out,
  input  logic             alu_zflag,
  input  logic             alu_sflag,
  input  logic             alu_cflag,
  input  logic             alu_pflag,
  output logic             busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(ALU_LAT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SETTLE, S_RESP} state_e;

  typedef struct packed {
`ifdef ALU_SEQ_CHAIN_EN
    logic             chain;
`endif
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [3:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  // FIFO storage and pointers
  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full, empty, push, pop;
  cmd_t             cmd_in, head;

  // Sequencer state and registered outputs
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [N-1:0]     rsp_data_q, rsp_data_d;
  logic [4:0]       rsp_flags_q, rsp_flags_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

`ifdef ALU_SEQ_CHAIN_EN
  logic [N-1:0]     last_q, last_d;
`else
  logic             unused_chain;
  assign unused_chain = cmd_chain;
`endif

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    cmd_in     = '0;
`ifdef ALU_SEQ_CHAIN_EN
    cmd_in.chain = cmd_chain;
`endif
    cmd_in.a   = cmd_a;
    cmd_in.b   = cmd_b;
    cmd_in.op  = cmd_op;
    cmd_in.tag = cmd_tag;
  end

  // Pointer/count bookkeeping; push and pop in one cycle cancel in the count
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  // FIFO payload; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_d     = start_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    tag_d       = tag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_tag_d   = rsp_tag_q;
    pop         = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // Issue only once the response slot is free
        if (!empty && !rsp_valid_q) begin
          pop     = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
          a_d     = head.chain ? last_q : head.a;
`else
          a_d     = head.a;
`endif
          b_d     = head.b;
          op_d    = head.op;
          tag_d   = head.tag;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(ALU_LAT - 1)) begin
          start_d = 1'b0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        // start is low this cycle so the ALU can drop op_done; result is final
        rsp_data_d  = alu_y_out;
        rsp_flags_d = {alu_c_out, alu_zflag, alu_sflag, alu_cflag, alu_pflag};
        rsp_tag_d   = tag_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
`ifdef ALU_SEQ_CHAIN_EN
        last_d      = alu_y_out;
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight command and empties the FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_tag_q   <= '0;
`ifdef ALU_SEQ_CHAIN_EN
      last_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_tag_q   <= rsp_tag_d;
`ifdef ALU_SEQ_CHAIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign cmd_ready  = !full;
  assign busy       = (state_q != S_IDLE) || !empty;
  assign alu_a_in   = a_q;
  assign alu_b_in   = b_q;
  assign alu_opcode = op_q;
  assign alu_start  = start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_tag    = rsp_tag_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer with a small behavioural ALU.
module tb_alu_cmd_sequencer;

  localparam int unsigned N     = 16;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid, cmd_ready, cmd_chain;
  logic [N-1:0]     cmd_a, cmd_b;
  logic [3:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic             rsp_valid, rsp_ready;
  logic [N-1:0]     rsp_data;
  logic [4:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic [N-1:0]     alu_a_in, alu_b_in, alu_y_out;
  logic [3:0]       alu_opcode;
  logic             alu_start, busy;
  logic             alu_c_out, alu_zflag, alu_sflag, alu_cflag, alu_pflag;

  alu_cmd_sequencer #(.N(N), .DEPTH(4), .TAG_W(TAG_W), .ALU_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .cmd_chain(cmd_chain),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .alu_a_in(alu_a_in), .alu_b_in(alu_b_in), .alu_opcode(alu_opcode),
    .alu_start(alu_start), .alu_y_out(alu_y_out),
    .alu_c_out(alu_c_out), .alu_zflag(alu_zflag), .alu_sflag(alu_sflag),
    .alu_cflag(alu_cflag), .alu_pflag(alu_pflag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: computes while start is high, holds afterwards
  logic [N-1:0] m_y;
  logic         m_c;
  always @(posedge clk) begin
    if (alu_start) begin
      case (alu_opcode)
        4'd0:    {m_c, m_y} <= {1'b0, alu_a_in} + {1'b0, alu_b_in};
        4'd1:    {m_c, m_y} <= {1'b0, alu_a_in} - {1'b0, alu_b_in};
        4'd2:    {m_c, m_y} <= {1'b0, alu_a_in} + 17'd1;
        default: {m_c, m_y} <= {1'b0, alu_a_in & alu_b_in};
      endcase
    end
  end
  assign alu_y_out = m_y;
  assign alu_c_out = m_c;
  assign alu_zflag = (m_y == '0);
  assign alu_sflag = m_y[N-1];
  assign alu_cflag = m_c;
  assign alu_pflag = ^m_y;

  // Start-pulse monitor: run lengths and overlap with a held response
  int run = 0, last_run = 0, bad_runs = 0, overlap = 0;
  always @(negedge clk) begin
    if (alu_start === 1'b1) begin
      run = run + 1;
      if (rsp_valid === 1'b1) overlap = overlap + 1;
    end else if (run != 0) begin
      last_run = run;
      if (run != 2) bad_runs = bad_runs + 1;
      run = 0;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] op,
                      input logic [TAG_W-1:0] tag, input logic chain);
    int w;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_chain = chain;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin step(); w++; end
    if (!cmd_ready) check("send_timeout", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic recv(output logic [N-1:0] d, output logic [4:0] f, output logic [TAG_W-1:0] t);
    int w;
    w = 0;
    while (!rsp_valid && w < 50) begin step(); w++; end
    if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
    d = rsp_data; f = rsp_flags; t = rsp_tag;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  logic [N-1:0]     d;
  logic [4:0]       f;
  logic [TAG_W-1:0] t;
  int               edges, got, seen;
  logic             rdy [6];
  logic [TAG_W-1:0] tags [6];
  logic [N-1:0]     datas [6];
  logic             acc;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_chain = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    repeat (3) step();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_start", 32'(alu_start), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_alu_a",     32'(alu_a_in),  32'd0);
    reset = 1'b0;
    step();

    // ADD 3+4 into idle block: latency and start width
    send(16'h0003, 16'h0004, 4'd0, 4'd1, 1'b0);
    edges = 0;
    while (!rsp_valid && edges < 20) begin step(); edges++; end
    check("add_latency", 32'(edges), 32'd4);
    check("add_start_len", 32'(last_run), 32'd2);
    recv(d, f, t);
    check("add_data", 32'(d), 32'h0007);
    check("add_c_out", 32'(f[4]), 32'd0);
    check("add_zflag", 32'(f[3]), 32'd0);
    check("add_tag", 32'(t), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // SUB 5-5
    send(16'h0005, 16'h0005, 4'd1, 4'd2, 1'b0);
    recv(d, f, t);
    check("sub_data",  32'(d), 32'h0000);
    check("sub_zflag", 32'(f[3]), 32'd1);
    check("sub_pflag", 32'(f[0]), 32'd0);

    // ADD FFFF+1 wraps with carry
    send(16'hFFFF, 16'h0001, 4'd0, 4'd3, 1'b0);
    recv(d, f, t);
    check("wrap_data",  32'(d), 32'h0000);
    check("wrap_c_out", 32'(f[4]), 32'd1);
    check("wrap_zflag", 32'(f[3]), 32'd1);

    // Back-pressure: fill FIFO with response held, then drain in order
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_a = N'(i); cmd_b = 16'h0010; cmd_op = 4'd0; cmd_tag = TAG_W'(i); cmd_chain = 1'b0;
      cmd_valid = 1'b1;
      rdy[i] = cmd_ready;
      if (i < 5) step();
    end
    for (int i = 0; i < 6; i++)
      check($sformatf("fill_ready%0d", i), 32'(rdy[i]), (i < 5) ? 32'd1 : 32'd0);
    rsp_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      if (rsp_valid) begin tags[got] = rsp_tag; datas[got] = rsp_data; got++; end
      acc = cmd_valid && cmd_ready;
      step();
      if (acc) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("drain_count", 32'(got), 32'd6);
    for (int i = 0; i < got; i++)
      check($sformatf("order%0d", i), {12'h0, tags[i], datas[i]}, 32'(i * 65536 + 16 + i));

    // Reset during RUN with two commands queued
    rsp_ready = 1'b1;
    cmd_a = 16'h0011; cmd_b = 16'h0022; cmd_op = 4'd0; cmd_tag = 4'd7; cmd_valid = 1'b1;
    step();
    cmd_tag = 4'd8; step();
    cmd_tag = 4'd9; step();
    cmd_valid = 1'b0;
    check("pre_rst_start", 32'(alu_start), 32'd1);
    reset = 1'b1;
    step();
    check("mid_rst_start",     32'(alu_start), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_rsp_data",  32'(rsp_data),  32'd0);
    reset = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (rsp_valid || alu_start) seen++;
      step();
    end
    check("post_rst_quiet", 32'(seen), 32'd0);
    rsp_ready = 1'b0;

    // Chained pair: INC 0x00FF, then ADD with chain=1, a=0x1234, b=1
    send(16'h00FF, 16'h0000, 4'd2, 4'd4, 1'b0);
    send(16'h1234, 16'h0001, 4'd0, 4'd5, 1'b1);
    recv(d, f, t);
    check("chain_first", 32'(d), 32'h0100);
    recv(d, f, t);
`ifdef ALU_SEQ_CHAIN_EN
    check("chain_second", 32'(d), 32'h0101);
`else
    check("chain_second", 32'(d), 32'h1235);
`endif
    check("chain_tag", 32'(t), 32'd5);

    repeat (3) step();
    check("start_during_rsp", 32'(overlap), 32'd0);
    check("start_run_lengths", 32'(bad_runs), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
